// File: rtl/sdram_port_arbiter.sv
// Round-robin, burst-locked arbiter of N_PORTS access queues onto one SDRAM command port; grant costs one IDLE cycle, beats are combinational.
// Backpressure: CMD_ACK_IN gates each beat; read beats stall while the outstanding-read tag FIFO is full.
package SDRAM_PKG;
    typedef logic [15:0] data_t;
    typedef struct packed {
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        data_t       wdata;
    } dram_access_t;
endpackage

module sdram_port_arbiter #(
    parameter int N_PORTS        = 4,
    parameter int N_BURSTS       = 8,
    parameter int TAG_DEPTH_LOG2 = 3
) (
    input  logic                                      CLK,
    input  logic                                      RESET_IN,
    input  logic [N_PORTS-1:0]                        PORT_WRITE_IN,
    input  SDRAM_PKG::dram_access_t [N_PORTS-1:0]     PORT_ACS_IN,
    input  logic [N_PORTS-1:0]                        PORT_RCHG_IN,
    input  logic [N_PORTS-1:0]                        PORT_REQ_IN,
    output logic [N_PORTS-1:0]                        PORT_ACK_OUT,
    output SDRAM_PKG::data_t [N_PORTS-1:0]            PORT_DATA_OUT,
    output logic [N_PORTS-1:0]                        PORT_RVALID_OUT,
    output logic                                      CMD_WRITE_OUT,
    output SDRAM_PKG::dram_access_t                   CMD_ACS_OUT,
    output logic                                      CMD_RCHG_OUT,
    output logic                                      CMD_REQ_OUT,
    input  logic                                      CMD_ACK_IN,
    input  SDRAM_PKG::data_t                          RD_DATA_IN,
    input  logic                                      RD_VALID_IN,
    output logic                                      RD_ERR_OUT
);
    localparam int GW    = $clog2(N_PORTS);
    localparam int BW    = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
    localparam int DEPTH = 1 << TAG_DEPTH_LOG2;
    localparam int CW    = TAG_DEPTH_LOG2 + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   last_q, last_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [GW-1:0]   tag_mem_q [DEPTH];
    logic [TAG_DEPTH_LOG2-1:0] tag_wr_ptr_q, tag_rd_ptr_q;
    logic [CW-1:0]   tag_cnt_q;

    SDRAM_PKG::data_t [N_PORTS-1:0] rd_data_q;
    logic [N_PORTS-1:0] rvalid_q;
    logic            rd_err_q;

    logic [GW-1:0]   pick;
    logic [GW-1:0]   idx;
    logic            found;
    logic            req_g, wr_g, rchg_g, other_req;
    logic            tag_full, tag_empty;
    logic            rchg_yield, last_beat;
    logic            cmd_req, beat, tag_push, tag_pop;
    logic [GW-1:0]   tag_head;

    // Rotating priority starts just after the most recently released port.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_PORTS; i++) begin
            idx = GW'((int'(last_q) + i) % N_PORTS);
            if (!found && PORT_REQ_IN[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign req_g      = PORT_REQ_IN[gnt_q];
    assign wr_g       = PORT_WRITE_IN[gnt_q];
    assign rchg_g     = PORT_RCHG_IN[gnt_q];
    assign other_req  = |(PORT_REQ_IN & ~(N_PORTS'(1) << gnt_q));
    assign tag_full   = (tag_cnt_q == CW'(DEPTH));
    assign tag_empty  = (tag_cnt_q == '0);
    assign rchg_yield = req_g & rchg_g & (beat_cnt_q != '0) & other_req;
    assign last_beat  = (beat_cnt_q == BW'(N_BURSTS - 1));
    assign beat       = cmd_req & CMD_ACK_IN;

    // State register
    always_ff @(posedge CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_q     <= GW'(N_PORTS - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|PORT_REQ_IN) begin
                    gnt_d      = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                if (!req_g || rchg_yield || (beat && last_beat)) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_req      = 1'b0;
        PORT_ACK_OUT = '0;
        if (state_q == GRANT) begin
            cmd_req = req_g & ~(~wr_g & tag_full) & ~rchg_yield;
            PORT_ACK_OUT[gnt_q] = cmd_req & CMD_ACK_IN;
        end
    end

    assign CMD_REQ_OUT   = cmd_req;
    assign CMD_WRITE_OUT = wr_g;
    assign CMD_ACS_OUT   = PORT_ACS_IN[gnt_q];
    assign CMD_RCHG_OUT  = rchg_g;

    // Tags record the issuing port of each read so in-order data can be routed back.
    assign tag_push = beat & ~wr_g;
    assign tag_pop  = RD_VALID_IN & ~tag_empty;
    assign tag_head = tag_mem_q[tag_rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (tag_push) begin
            tag_mem_q[tag_wr_ptr_q] <= gnt_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr_q <= tag_wr_ptr_q + 1'b1;
            end
            if (tag_pop) begin
                tag_rd_ptr_q <= tag_rd_ptr_q + 1'b1;
            end
            tag_cnt_q <= tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
        end
    end

    always_ff @(posedge CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            rd_data_q <= '0;
            rvalid_q  <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            rvalid_q <= '0;
            if (tag_pop) begin
                rd_data_q[tag_head] <= RD_DATA_IN;
                rvalid_q[tag_head]  <= 1'b1;
            end
            if (RD_VALID_IN && tag_empty) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign PORT_DATA_OUT   = rd_data_q;
    assign PORT_RVALID_OUT = rvalid_q;
    assign RD_ERR_OUT      = rd_err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: queue-level behavioural model checked every cycle plus literal expectations per scenario.
module tb_sdram_port_arbiter;
    localparam int NP = 4;
    localparam int NB = 8;
    localparam int TDL = 2;
    localparam int TDEPTH = 1 << TDL;

    typedef struct packed {
        logic wr;
        logic rc;
        SDRAM_PKG::dram_access_t a;
    } ent_t;

    logic CLK = 1'b0;
    logic RESET_IN = 1'b1;
    logic [NP-1:0] port_write = '0, port_rchg = '0, port_req = '0;
    SDRAM_PKG::dram_access_t [NP-1:0] port_acs = '0;
    logic [NP-1:0] port_ack, port_rvalid;
    SDRAM_PKG::data_t [NP-1:0] port_data;
    logic cmd_write, cmd_rchg, cmd_req, rd_err;
    SDRAM_PKG::dram_access_t cmd_acs;
    logic cmd_ack = 1'b0, rd_vld = 1'b0;
    SDRAM_PKG::data_t rd_dat = '0;

    logic reset_nx = 1'b1, cmd_ack_nx = 1'b0, rd_vld_nx = 1'b0;
    SDRAM_PKG::data_t rd_dat_nx = '0;
    ent_t srcq [NP][$];
    logic [NP-1:0] ack_neg = '0;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_port_arbiter #(.N_PORTS(NP), .N_BURSTS(NB), .TAG_DEPTH_LOG2(TDL)) dut (
        .CLK(CLK), .RESET_IN(RESET_IN),
        .PORT_WRITE_IN(port_write), .PORT_ACS_IN(port_acs), .PORT_RCHG_IN(port_rchg),
        .PORT_REQ_IN(port_req), .PORT_ACK_OUT(port_ack), .PORT_DATA_OUT(port_data),
        .PORT_RVALID_OUT(port_rvalid), .CMD_WRITE_OUT(cmd_write), .CMD_ACS_OUT(cmd_acs),
        .CMD_RCHG_OUT(cmd_rchg), .CMD_REQ_OUT(cmd_req), .CMD_ACK_IN(cmd_ack),
        .RD_DATA_IN(rd_dat), .RD_VALID_IN(rd_vld), .RD_ERR_OUT(rd_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- DUT observation: per-port beat counts and grant runs
    int ack_cnt [NP];
    int run_port[$];
    int run_len[$];
    logic run_rc[$];
    int prev_p = -1;

    always @(negedge CLK) begin
        int p;
        ack_neg = port_ack;
        if (RESET_IN) begin
            for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
            run_port.delete(); run_len.delete(); run_rc.delete();
            prev_p = -1;
        end else begin
            p = -1;
            for (int i = 0; i < NP; i++) if (port_ack[i]) p = i;
            if (p >= 0) begin
                ack_cnt[p]++;
                if (p != prev_p) begin
                    run_port.push_back(p); run_len.push_back(1); run_rc.push_back(cmd_rchg);
                end else begin
                    run_len[run_len.size()-1]++;
                end
            end
            prev_p = p;
        end
    end

    // ---------------- Behavioural model and per-cycle compare
    int m_gnt, m_last, m_beats;
    int m_tags[$];
    int m_glog[$];
    SDRAM_PKG::data_t m_data [NP];
    logic [NP-1:0] m_rv;
    logic m_err;

    always @(negedge CLK) begin
        int g, t;
        logic rc_rel, exp_req, is_beat, found;
        logic [NP-1:0] exp_ack, nrv;
        if (RESET_IN) begin
            m_gnt = -1; m_last = NP - 1; m_beats = 0;
            m_tags.delete(); m_glog.delete();
            for (int i = 0; i < NP; i++) m_data[i] = '0;
            m_rv = '0; m_err = 1'b0;
            chk("rst_cmd_req", cmd_req, 0);
            chk("rst_ack", port_ack, 0);
            chk("rst_rvalid", port_rvalid, 0);
            chk("rst_err", rd_err, 0);
        end else begin
            g = m_gnt; rc_rel = 1'b0; exp_req = 1'b0; exp_ack = '0;
            if (g >= 0) begin
                rc_rel = port_req[g] && port_rchg[g] && m_beats > 0 && ((port_req & ~(4'b0001 << g)) != 0);
                exp_req = port_req[g] && !rc_rel && !(!port_write[g] && m_tags.size() == TDEPTH);
                if (exp_req && cmd_ack) exp_ack[g] = 1'b1;
            end
            chk("mdl_cmd_req", cmd_req, exp_req);
            chk("mdl_ack", port_ack, exp_ack);
            if (exp_req) begin
                chk("mdl_cmd_write", cmd_write, port_write[g]);
                chk("mdl_cmd_rchg", cmd_rchg, port_rchg[g]);
                chk("mdl_cmd_acs", cmd_acs, port_acs[g]);
            end
            chk("mdl_rvalid", port_rvalid, m_rv);
            chk("mdl_err", rd_err, m_err);
            for (int i = 0; i < NP; i++) chk("mdl_data", port_data[i], m_data[i]);

            nrv = '0;
            if (rd_vld) begin
                if (m_tags.size() > 0) begin
                    t = m_tags.pop_front();
                    m_data[t] = rd_dat;
                    nrv[t] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_rv = nrv;
            is_beat = exp_req && cmd_ack;
            if (is_beat && !port_write[g]) m_tags.push_back(g);
            if (g < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NP; k++) begin
                    int p;
                    p = (m_last + k) % NP;
                    if (!found && port_req[p]) begin
                        found = 1'b1; m_gnt = p; m_beats = 0; m_glog.push_back(p);
                    end
                end
            end else begin
                if (is_beat) m_beats++;
                if (!port_req[g] || rc_rel || (is_beat && m_beats == NB)) begin
                    m_last = g; m_gnt = -1;
                end
            end
        end
    end

    // ---------------- Stimulus helpers
    task automatic step();
        @(posedge CLK);
        #1;
        for (int i = 0; i < NP; i++)
            if (ack_neg[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (reset_nx)
            for (int i = 0; i < NP; i++) srcq[i].delete();
        RESET_IN = reset_nx;
        cmd_ack  = cmd_ack_nx;
        rd_vld   = rd_vld_nx;
        rd_dat   = rd_dat_nx;
        for (int i = 0; i < NP; i++) begin
            if (srcq[i].size() > 0) begin
                port_req[i] = 1'b1; port_write[i] = srcq[i][0].wr;
                port_rchg[i] = srcq[i][0].rc; port_acs[i] = srcq[i][0].a;
            end else begin
                port_req[i] = 1'b0; port_write[i] = 1'b0; port_rchg[i] = 1'b0; port_acs[i] = '0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input int p, input int k, input logic wr, input logic rc);
        ent_t e;
        e.wr = wr; e.rc = rc;
        e.a.bank = 2'(p); e.a.row = 13'(k); e.a.col = 10'(k * 3 + p);
        e.a.wdata = 16'(16'h1000 * p + k);
        srcq[p].push_back(e);
    endtask

    task automatic do_reset();
        reset_nx = 1'b1; run(2);
        reset_nx = 1'b0; step();
    endtask

    initial begin
        // Reset values
        run(2);
        @(negedge CLK);
        chk("reset_cmd_req", cmd_req, 0);
        chk("reset_rvalid", port_rvalid, 0);
        chk("reset_err", rd_err, 0);
        chk("reset_data0", port_data[0], 0);
        reset_nx = 1'b0; cmd_ack_nx = 1'b1; step();

        // Single port, three writes
        for (int k = 0; k < 3; k++) push(1, k, 1'b1, 1'b0);
        step();
        @(negedge CLK);
        chk("t1_idle_cycle_req", cmd_req, 0);
        step();
        @(negedge CLK);
        chk("t1_first_req", cmd_req, 1);
        chk("t1_first_ack", port_ack, 4'b0010);
        chk("t1_write_flag", cmd_write, 1);
        run(6);
        chk("t1_beats", ack_cnt[1], 3);
        chk("t1_runs", run_port.size(), 1);

        // Four ports, continuous writes
        do_reset();
        for (int p = 0; p < NP; p++) for (int k = 0; k < 16; k++) push(p, k, 1'b1, 1'b0);
        run(50);
        chk("t2_nruns_ge5", run_port.size() >= 5, 1);
        chk("t2_model_log_ge5", m_glog.size() >= 5, 1);
        if (run_port.size() >= 5 && m_glog.size() >= 5) begin
            chk("t2_run0_port", run_port[0], 0);
            chk("t2_run1_port", run_port[1], 1);
            chk("t2_run2_port", run_port[2], 2);
            chk("t2_run3_port", run_port[3], 3);
            chk("t2_run4_port", run_port[4], 0);
            for (int r = 0; r < 4; r++) chk("t2_run_len", run_len[r], 8);
            chk("t2_model_g0", m_glog[0], 0);
            chk("t2_model_g3", m_glog[3], 3);
            chk("t2_model_g4", m_glog[4], 0);
        end

        // Row change under contention
        do_reset();
        push(0, 0, 1'b1, 1'b0); push(0, 1, 1'b1, 1'b0); push(0, 2, 1'b1, 1'b1); push(0, 3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) push(2, k, 1'b1, 1'b0);
        run(20);
        chk("t3_nruns", run_port.size(), 3);
        if (run_port.size() == 3) begin
            chk("t3_run0", {run_port[0][7:0], run_len[0][7:0]}, 16'h0002);
            chk("t3_run1", {run_port[1][7:0], run_len[1][7:0]}, 16'h0203);
            chk("t3_run2", {run_port[2][7:0], run_len[2][7:0]}, 16'h0002);
            chk("t3_run2_rchg", run_rc[2], 1);
        end

        // Tag FIFO full stalls reads
        do_reset();
        for (int k = 0; k < 8; k++) push(2, k, 1'b0, 1'b0);
        run(12);
        @(negedge CLK);
        chk("t4_beats_at_full", ack_cnt[2], 4);
        chk("t4_stalled", cmd_req, 0);
        rd_vld_nx = 1'b1; rd_dat_nx = 16'hA5A5; step();
        rd_vld_nx = 1'b0;
        @(negedge CLK);
        chk("t4_no_bypass", cmd_req, 0);
        step();
        @(negedge CLK);
        chk("t4_data2", port_data[2], 16'hA5A5);
        chk("t4_rvalid", port_rvalid, 4'b0100);
        chk("t4_resume", cmd_req, 1);

        // Interleaved read return
        do_reset();
        push(0, 5, 1'b0, 1'b0); push(3, 6, 1'b0, 1'b0);
        run(10);
        rd_vld_nx = 1'b1; rd_dat_nx = 16'h1111; step();
        rd_dat_nx = 16'h3333; step();
        rd_vld_nx = 1'b0;
        @(negedge CLK);
        chk("t5_data0", port_data[0], 16'h1111);
        chk("t5_rvalid0", port_rvalid, 4'b0001);
        step();
        @(negedge CLK);
        chk("t5_data3", port_data[3], 16'h3333);
        chk("t5_rvalid3", port_rvalid, 4'b1000);
        chk("t5_data0_hold", port_data[0], 16'h1111);

        // Stray read data, then reset mid-grant
        rd_vld_nx = 1'b1; rd_dat_nx = 16'h7777; step();
        rd_vld_nx = 1'b0; step();
        @(negedge CLK);
        chk("t6_err_set", rd_err, 1);
        run(4);
        @(negedge CLK);
        chk("t6_err_sticky", rd_err, 1);
        for (int k = 0; k < 6; k++) push(1, k, 1'b0, 1'b0);
        run(4);
        @(negedge CLK);
        chk("t6_mid_grant_req", cmd_req, 1);
        #2;
        RESET_IN = 1'b1; reset_nx = 1'b1;
        #1;
        chk("t6_async_req", cmd_req, 0);
        chk("t6_async_err", rd_err, 0);
        chk("t6_async_ack", port_ack, 0);
        run(2);
        reset_nx = 1'b0; step();
        rd_vld_nx = 1'b1; rd_dat_nx = 16'hBEEF; step();
        rd_vld_nx = 1'b0; step();
        @(negedge CLK);
        chk("t6_lost_tag_err", rd_err, 1);
        chk("t6_lost_tag_rvalid", port_rvalid, 0);
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Consumer side of the per-port SDRAM access queues.
- Takes N_PORTS queued access streams (write flag, access, row-change flag, req/ack) and arbitrates them round-robin with burst locking.
- Forwards one stream at a time onto the single SDRAM controller command interface.
- Routes in-order read data back to the issuing port using a tag FIFO.

Parameters:
- N_PORTS, 4, number of upstream queue ports (2..8).
- N_BURSTS, 8, maximum beats accepted from one port per grant.
- TAG_DEPTH_LOG2, 3, log2 of the outstanding-read tag FIFO depth.

Ports:
- CLK  in  1  clock
- RESET_IN  in  1  asynchronous, active-high reset
- PORT_WRITE_IN  in  N_PORTS  per-port write(1)/read(0) flag of head entry
- PORT_ACS_IN  in  N_PORTS x SDRAM_PKG::dram_access_t  per-port head access
- PORT_RCHG_IN  in  N_PORTS  per-port row-change flag of head entry
- PORT_REQ_IN  in  N_PORTS  per-port head entry valid
- PORT_ACK_OUT  out  N_PORTS  per-port pop strobe (beat accepted downstream)
- PORT_DATA_OUT  out  N_PORTS x SDRAM_PKG::data_t  per-port registered read data
- PORT_RVALID_OUT  out  N_PORTS  one-cycle strobe, PORT_DATA_OUT[i] updated
- CMD_WRITE_OUT  out  1  forwarded write flag
- CMD_ACS_OUT  out  dram_access_t  forwarded access
- CMD_RCHG_OUT  out  1  forwarded row-change flag
- CMD_REQ_OUT  out  1  command valid
- CMD_ACK_IN  in  1  controller accepts command this cycle
- RD_DATA_IN  in  SDRAM_PKG::data_t  read data from controller, in issue order
- RD_VALID_IN  in  1  RD_DATA_IN valid
- RD_ERR_OUT  out  1  sticky: RD_VALID_IN seen with tag FIFO empty

Behaviour:
- Reset (async): state IDLE, gnt=0, last=N_PORTS-1, beat_cnt=0, tag FIFO empty. PORT_DATA_OUT, PORT_RVALID_OUT and RD_ERR_OUT are 0. CMD_REQ_OUT=0 and PORT_ACK_OUT=0 via IDLE.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any PORT_REQ_IN, register gnt = first requesting port searching last+1, last+2, ... modulo N_PORTS.
  - Set beat_cnt=0 and go to GRANT on the next cycle.
  - Otherwise stay in IDLE.
- GRANT, combinational forwarding:
  - CMD_WRITE/ACS/RCHG_OUT = port[gnt] fields.
  - CMD_REQ_OUT = PORT_REQ_IN[gnt] & ~(~PORT_WRITE_IN[gnt] & tag_full).
  - In every other state the CMD_* fields are don't-care and CMD_REQ_OUT=0.
- Beat: CMD_REQ_OUT & CMD_ACK_IN.
  - PORT_ACK_OUT[gnt]=1 that cycle (combinational from CMD_ACK_IN); all other PORT_ACK_OUT bits are 0.
  - beat_cnt increments.
  - A read beat pushes gnt into the tag FIFO.
- GRANT -> IDLE, with last <= gnt, when any of:
  - a beat occurs with beat_cnt==N_BURSTS-1;
  - PORT_REQ_IN[gnt]==0 (gap in stream);
  - a beat is not taken because PORT_RCHG_IN[gnt]=1, beat_cnt>0 and another port requests. A row change forfeits the lock only under contention; CMD_REQ_OUT is held 0 that cycle.
- Re-arbitration costs exactly one IDLE cycle between grants. A port alone on the bus is re-granted after that dead cycle.
- Tag FIFO:
  - Depth 2^TAG_DEPTH_LOG2, width $clog2(N_PORTS).
  - tag_full is derived from the registered count only; there is no pop-bypass. A full FIFO blocks read beats even when a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
- Read return on RD_VALID_IN with FIFO non-empty:
  - Pop tag t.
  - Next cycle: PORT_DATA_OUT[t]=RD_DATA_IN registered, PORT_RVALID_OUT[t]=1 for one cycle.
  - Other ports' PORT_DATA_OUT hold their value.
- RD_VALID_IN with FIFO empty: data dropped, RD_ERR_OUT set until reset.
- Write beats never push tags. Writes and reads from the same port may interleave within a grant.
- Reset mid-burst: in-flight tags are lost. Read data returning after reset is treated as an empty-FIFO return and sets RD_ERR_OUT.

Test Plan:
- Reset, then port 1 only: 3 write beats, CMD_ACK_IN=1 -> grant asserts 1 cycle after REQ; PORT_ACK_OUT=4'b0010 for 3 cycles; CMD_WRITE_OUT=1; then IDLE.
- All 4 ports requesting continuously, N_BURSTS=8, CMD_ACK_IN=1 -> grants in order 0,1,2,3,0. Each grant carries exactly 8 beats, separated by 1 dead cycle.
- Ports 0 and 2 requesting, port 0's 3rd beat has RCHG=1 -> port 0 released after 2 beats; port 2 granted next; port 0's RCHG beat is issued on its next grant.
- 8 read beats from port 2, TAG_DEPTH_LOG2=2, RD_VALID_IN withheld -> CMD_REQ_OUT drops after 4 beats. Returning 1 read datum (0xA5A5) -> PORT_DATA_OUT[2]=0xA5A5 and PORT_RVALID_OUT=4'b0100 one cycle later; issue resumes.
- Interleaved reads: port 0 then port 3, data returned D0, D3 -> D0 appears on PORT_DATA_OUT[0] and D3 on PORT_DATA_OUT[3], each with a 1-cycle RVALID strobe.
- RD_VALID_IN with no outstanding reads -> RD_ERR_OUT=1, held until RESET_IN. Asserting RESET_IN mid-grant -> CMD_REQ_OUT=0 immediately and RD_ERR_OUT cleared.
